// File: rtl/imm_ext_arbiter.sv
// -----------------------------------------------------------------------------
// imm_ext_arbiter
//
// Shares one combinational sign_extend_shifter between two requesters:
// A (branch/jump unit) and B (load/store address unit). A single-entry output
// register captures the extender result. Simultaneous requests are resolved
// round-robin. One result per clock is sustained while the consumer keeps
// rsp_ready high.
//
// Ports
//   clk, reset_n          rising-edge clock, asynchronous active-low reset
//   a_valid/a_data/a_jump requester A request, immediate and shift select
//   a_ready               A accepted this cycle (combinational)
//   b_valid/b_data/b_jump requester B request, immediate and shift select
//   b_ready               B accepted this cycle (combinational)
//   sx_data_in, sx_jump   drive the shared extender (granted requester, else A)
//   sx_data_out           combinational extender result
//   rsp_valid/rsp_ready   registered result handshake
//   rsp_data, rsp_id      registered result and its owner (0 = A, 1 = B)
//   a_count, b_count      saturating grant counters
// -----------------------------------------------------------------------------
module imm_ext_arbiter #(
    parameter int IN_W  = 12,
    parameter int OUT_W = 16,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             a_valid,
    input  logic [IN_W-1:0]  a_data,
    input  logic             a_jump,
    output logic             a_ready,
    input  logic             b_valid,
    input  logic [IN_W-1:0]  b_data,
    input  logic             b_jump,
    output logic             b_ready,
    output logic [IN_W-1:0]  sx_data_in,
    output logic             sx_jump,
    input  logic [OUT_W-1:0] sx_data_out,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [OUT_W-1:0] rsp_data,
    output logic             rsp_id,
    output logic [CNT_W-1:0] a_count,
    output logic [CNT_W-1:0] b_count
);

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } state_t;

    state_t state;
    state_t state_next;
    logic   last_grant;   // 0 = A, 1 = B
    logic   accept;
    logic   grant_a;
    logic   grant_b;

    // NOTE: state registers use non-blocking assignments so every flop samples
    // pre-edge values regardless of process ordering in simulation.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= EMPTY;
        end else begin
            state <= state_next;
        end
    end

    // NOTE: every signal written here gets a default first, so no path leaves
    // it unassigned and no latch is inferred.
    always_comb begin
        state_next = state;
        accept     = 1'b0;
        grant_a    = 1'b0;
        grant_b    = 1'b0;

        // The slot frees up in the same cycle the consumer drains it. Gating
        // with reset_n keeps both ready outputs low while reset is held.
        accept = reset_n && ((state == EMPTY) || rsp_ready);

        // Round-robin on a tie: the requester not granted most recently wins.
        grant_a = accept && a_valid && (!b_valid || last_grant);
        grant_b = accept && b_valid && (!a_valid || !last_grant);

        if (grant_a || grant_b) begin
            state_next = FULL;
        end else if ((state == FULL) && rsp_ready) begin
            state_next = EMPTY;
        end
    end

    assign a_ready    = grant_a;
    assign b_ready    = grant_b;
    assign sx_data_in = grant_b ? b_data : a_data;
    assign sx_jump    = grant_b ? b_jump : a_jump;
    assign rsp_valid  = (state == FULL);

    // NOTE: the result register is reset along with the control state, so a
    // response held at reset is cleared to zero rather than left stale.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rsp_data   <= '0;
            rsp_id     <= 1'b0;
            last_grant <= 1'b1;
        end else if (grant_a || grant_b) begin
            rsp_data   <= sx_data_out;
            rsp_id     <= grant_b;
            last_grant <= grant_b;
        end
    end

    // Counters stop at all-ones instead of wrapping.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            a_count <= '0;
            b_count <= '0;
        end else begin
            if (grant_a && (a_count != '1)) a_count <= a_count + CNT_W'(1);
            if (grant_b && (b_count != '1)) b_count <= b_count + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_imm_ext_arbiter.sv
// -----------------------------------------------------------------------------
// tb_imm_ext_arbiter
//
// Directed bench for imm_ext_arbiter. The shared extender is stubbed as
// sx_data_out = {3'b000, sx_jump, sx_data_in}. The driver pushes the expected
// result of every grant it predicts into a queue; a monitor pops and compares
// whenever a result is handed off (rsp_valid && rsp_ready).
// -----------------------------------------------------------------------------
module tb_imm_ext_arbiter;

    localparam int IN_W  = 12;
    localparam int OUT_W = 16;
    localparam int CNT_W = 8;

    logic             clk;
    logic             reset_n;
    logic             a_valid;
    logic [IN_W-1:0]  a_data;
    logic             a_jump;
    logic             a_ready;
    logic             b_valid;
    logic [IN_W-1:0]  b_data;
    logic             b_jump;
    logic             b_ready;
    logic [IN_W-1:0]  sx_data_in;
    logic             sx_jump;
    logic [OUT_W-1:0] sx_data_out;
    logic             rsp_valid;
    logic             rsp_ready;
    logic [OUT_W-1:0] rsp_data;
    logic             rsp_id;
    logic [CNT_W-1:0] a_count;
    logic [CNT_W-1:0] b_count;

    typedef struct packed {
        logic             id;
        logic [OUT_W-1:0] data;
    } rsp_t;

    rsp_t       exp_q[$];
    int         checks;
    int         failures;
    logic       exp_full;
    int         exp_a_cnt;
    int         exp_b_cnt;

    imm_ext_arbiter #(.IN_W(IN_W), .OUT_W(OUT_W), .CNT_W(CNT_W)) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .a_valid    (a_valid),
        .a_data     (a_data),
        .a_jump     (a_jump),
        .a_ready    (a_ready),
        .b_valid    (b_valid),
        .b_data     (b_data),
        .b_jump     (b_jump),
        .b_ready    (b_ready),
        .sx_data_in (sx_data_in),
        .sx_jump    (sx_jump),
        .sx_data_out(sx_data_out),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_data   (rsp_data),
        .rsp_id     (rsp_id),
        .a_count    (a_count),
        .b_count    (b_count)
    );

    // Extender stub.
    assign sx_data_out = {3'b000, sx_jump, sx_data_in};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: inputs only change on the falling edge (or 3 ns after it for
    // the mid-cycle reset), so 2 ns after the falling edge everything is stable.
    always @(negedge clk) begin
        #2;
        if (reset_n && rsp_valid && rsp_ready) begin
            if (exp_q.size() == 0) begin
                check("rsp_unexpected", 32'(rsp_data), 32'hFFFF_FFFF);
            end else begin
                rsp_t e;
                e = exp_q.pop_front();
                check("rsp_data", 32'(rsp_data), 32'(e.data));
                check("rsp_id", 32'(rsp_id), 32'(e.id));
            end
        end
    end

    // One clock of stimulus. Before driving, state visible from the previous
    // edge is checked against the bench's own model; after driving, the
    // combinational ready outputs are checked and predicted grants recorded.
    task automatic step(input logic av, input logic [IN_W-1:0] ad, input logic aj,
                        input logic bv, input logic [IN_W-1:0] bd, input logic bj,
                        input logic rr, input logic exp_ga, input logic exp_gb);
        @(negedge clk);
        check("rsp_valid", 32'(rsp_valid), 32'(exp_full));
        check("a_count", 32'(a_count), 32'(exp_a_cnt));
        check("b_count", 32'(b_count), 32'(exp_b_cnt));
        a_valid   = av;
        a_data    = ad;
        a_jump    = aj;
        b_valid   = bv;
        b_data    = bd;
        b_jump    = bj;
        rsp_ready = rr;
        #1;
        check("a_ready", 32'(a_ready), 32'(exp_ga));
        check("b_ready", 32'(b_ready), 32'(exp_gb));
        if (exp_ga) begin
            exp_q.push_back('{id: 1'b0, data: {3'b000, aj, ad}});
            if (exp_a_cnt < 255) exp_a_cnt++;
        end
        if (exp_gb) begin
            exp_q.push_back('{id: 1'b1, data: {3'b000, bj, bd}});
            if (exp_b_cnt < 255) exp_b_cnt++;
        end
        if (exp_ga || exp_gb) exp_full = 1'b1;
        else if (rr)          exp_full = 1'b0;
    endtask

    task automatic idle();
        step(1'b0, '0, 1'b0, 1'b0, '0, 1'b0, 1'b1, 1'b0, 1'b0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset_n   = 1'b0;
        a_valid   = 1'b0;
        a_data    = '0;
        a_jump    = 1'b0;
        b_valid   = 1'b0;
        b_data    = '0;
        b_jump    = 1'b0;
        rsp_ready = 1'b0;
        exp_q.delete();
        exp_full  = 1'b0;
        exp_a_cnt = 0;
        exp_b_cnt = 0;
        @(negedge clk);
        @(negedge clk);
        reset_n = 1'b1;
    endtask

    initial begin
        checks    = 0;
        failures  = 0;
        reset_n   = 1'b1;
        do_reset();

        // Reset state.
        check("rst_rsp_data", 32'(rsp_data), 32'h0);
        check("rst_rsp_id", 32'(rsp_id), 32'h0);

        // Single request from A, result one clock later.
        step(1'b1, 12'h081, 1'b0, 1'b0, '0, 1'b0, 1'b1, 1'b1, 1'b0);
        idle();
        idle();

        // Tie after reset: A first, then alternating, one result per clock.
        do_reset();
        step(1'b1, 12'h800, 1'b1, 1'b1, 12'h001, 1'b0, 1'b1, 1'b1, 1'b0);
        step(1'b1, 12'h800, 1'b1, 1'b1, 12'h001, 1'b0, 1'b1, 1'b0, 1'b1);
        step(1'b1, 12'h800, 1'b1, 1'b1, 12'h001, 1'b0, 1'b1, 1'b1, 1'b0);
        step(1'b1, 12'h800, 1'b1, 1'b1, 12'h001, 1'b0, 1'b1, 1'b0, 1'b1);
        idle();

        // Backpressure: held result stays stable, no grants, then a grant in
        // the same cycle the consumer drains the slot.
        step(1'b0, '0, 1'b0, 1'b1, 12'h801, 1'b0, 1'b1, 1'b0, 1'b1);
        for (int i = 0; i < 3; i++) begin
            step(1'b1, 12'h123, 1'b0, 1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b0);
            check("bp_hold_data", 32'(rsp_data), 32'h0801);
            check("bp_hold_id", 32'(rsp_id), 32'h1);
        end
        step(1'b1, 12'h123, 1'b0, 1'b0, '0, 1'b0, 1'b1, 1'b1, 1'b0);
        idle();
        idle();

        // Valid dropped before being granted is not served.
        step(1'b1, 12'h0AA, 1'b0, 1'b0, '0, 1'b0, 1'b1, 1'b1, 1'b0);
        step(1'b0, '0, 1'b0, 1'b1, 12'h0BB, 1'b0, 1'b0, 1'b0, 1'b0);
        step(1'b0, '0, 1'b0, 1'b0, '0, 1'b0, 1'b1, 1'b0, 1'b0);
        idle();

        // Reset mid-operation while FULL: output clears without a clock edge.
        step(1'b1, 12'h055, 1'b0, 1'b0, '0, 1'b0, 1'b0, 1'b1, 1'b0);
        @(negedge clk);
        check("pre_rst_valid", 32'(rsp_valid), 32'h1);
        #3;
        reset_n = 1'b0;
        #1;
        check("async_rst_valid", 32'(rsp_valid), 32'h0);
        check("async_rst_data", 32'(rsp_data), 32'h0);
        check("async_rst_a_ready", 32'(a_ready), 32'h0);
        check("async_rst_a_count", 32'(a_count), 32'h0);
        exp_q.delete();
        exp_full  = 1'b0;
        exp_a_cnt = 0;
        exp_b_cnt = 0;
        @(negedge clk);
        a_valid = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
        idle();
        step(1'b1, 12'h111, 1'b0, 1'b1, 12'h222, 1'b1, 1'b1, 1'b1, 1'b0);
        step(1'b1, 12'h111, 1'b0, 1'b1, 12'h222, 1'b1, 1'b1, 1'b0, 1'b1);
        idle();

        // Counter saturation.
        do_reset();
        for (int i = 0; i < 260; i++) begin
            step(1'b1, 12'(i), 1'b0, 1'b0, '0, 1'b0, 1'b1, 1'b1, 1'b0);
        end
        idle();
        idle();
        check("sat_a_count", 32'(a_count), 32'hFF);
        check("sat_b_count", 32'(b_count), 32'h0);

        check("queue_drained", 32'(exp_q.size()), 32'h0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
